phase1_datapath: RTL and testbench

Single-bus 32-bit CPU datapath slice for phase-1 bring-up: PC, IR, MAR, MDR, Y, a 64-bit Z result register, general registers R0/R4/R5 and an ALU, all joined by one shared bus. A controller or testbench drives one-hot register load/drive strobes each cycle. The block has no instruction decode of its own; it only executes the control signals it is given. Register contents, bus value and internal registers are exposed as ports for observation.

---
 rtl/phase1_datapath.sv | 140 ++++++++++++++
 tb/tb_phase1_datapath.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/phase1_datapath.sv
// rtl/phase1_datapath.sv - single-bus 32-bit datapath slice: PC/IR/MAR/MDR/Y/Z, R0/R4/R5 and ALU
module phase1_datapath (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        R0in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        MDRin,
  input  logic        Zin,
  input  logic        IncrementPC,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        PCout,
  input  logic        ZLOout,
  input  logic        MDRout,
  input  logic        Read,
  input  logic [4:0]  ALUControl,
  input  logic [31:0] Mdatain,
  output logic [31:0] R0_data_out,
  output logic [31:0] R4_data_out,
  output logic [31:0] R5_data_out,
  output logic [31:0] big_boy_bus,
  output logic [31:0] MDR_data_in,
  output logic [31:0] MDR_data_out,
  output logic [31:0] Y_data_out,
  output logic [63:0] Z_data_out
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;

  logic [31:0] pc, ir, mar, mdr, y, r0, r4, r5;
  logic [63:0] z;
  logic [31:0] bus;
  logic [63:0] alu_result;

  logic [31:0] alu_a, alu_b;
  logic [4:0]  shamt;
  logic [63:0] rot_pair, rol_wide;
  logic signed [63:0] mul_prod;
  logic signed [31:0] div_quot, div_rem;

  // Bus priority: MDRout > ZLOout > PCout > R5out > R4out, 0 when idle.
  always_comb begin
    bus = 32'h0;
    if (MDRout)      bus = mdr;
    else if (ZLOout) bus = z[31:0];
    else if (PCout)  bus = pc;
    else if (R5out)  bus = r5;
    else if (R4out)  bus = r4;
  end

  assign MDR_data_in = Read ? Mdatain : bus;

  assign alu_a    = y;
  assign alu_b    = bus;
  assign shamt    = alu_b[4:0];
  assign rot_pair = {alu_a, alu_a};
  assign rol_wide = rot_pair << shamt;
  assign mul_prod = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});

  // Guard the divider so a zero divisor never reaches the operator.
  always_comb begin
    div_quot = 32'sd0;
    div_rem  = 32'sd0;
    if (alu_b != 32'h0) begin
      div_quot = $signed(alu_a) / $signed(alu_b);
      div_rem  = $signed(alu_a) % $signed(alu_b);
    end
  end

  always_comb begin
    alu_result = 64'h0;
    case (ALUControl)
      OP_ADD:  alu_result = {32'h0, alu_a + alu_b};
      OP_SUB:  alu_result = {32'h0, alu_a - alu_b};
      OP_AND:  alu_result = {32'h0, alu_a & alu_b};
      OP_OR:   alu_result = {32'h0, alu_a | alu_b};
      OP_SHR:  alu_result = {32'h0, alu_a >> shamt};
      OP_SHRA: alu_result = {32'h0, $unsigned($signed(alu_a) >>> shamt)};
      OP_SHL:  alu_result = {32'h0, alu_a << shamt};
      OP_ROR:  alu_result = {32'h0, rot_pair[31:0] >> shamt | rot_pair[63:32] << (6'd32 - {1'b0, shamt})};
      OP_ROL:  alu_result = {32'h0, rol_wide[63:32]};
      OP_MUL:  alu_result = $unsigned(mul_prod);
      OP_DIV:  alu_result = {$unsigned(div_rem), $unsigned(div_quot)};
      OP_NEG:  alu_result = {32'h0, 32'h0 - alu_b};
      OP_NOT:  alu_result = {32'h0, ~alu_b};
      default: alu_result = 64'h0;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc  <= 32'h0;
      ir  <= 32'h0;
      mar <= 32'h0;
      mdr <= 32'h0;
      y   <= 32'h0;
      z   <= 64'h0;
      r0  <= 32'h0;
      r4  <= 32'h0;
      r5  <= 32'h0;
    end else begin
      if (IncrementPC) pc <= pc + 32'd1;
      else if (PCin)   pc <= bus;
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus;
      if (MDRin) mdr <= MDR_data_in;
      if (Yin)   y   <= bus;
      if (Zin)   z   <= alu_result;
      if (R0in)  r0  <= bus;
      if (R4in)  r4  <= bus;
      if (R5in)  r5  <= bus;
    end
  end

  assign R0_data_out  = r0;
  assign R4_data_out  = r4;
  assign R5_data_out  = r5;
  assign big_boy_bus  = bus;
  assign MDR_data_out = mdr;
  assign Y_data_out   = y;
  assign Z_data_out   = z;

endmodule

// File: tb/tb_phase1_datapath.sv
// tb/tb_phase1_datapath.sv - directed self-checking bench for phase1_datapath
module tb_phase1_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        R0in, R4in, R5in, MARin, PCin, IRin, Yin, MDRin, Zin, IncrementPC;
  logic        R4out, R5out, PCout, ZLOout, MDRout, Read;
  logic [4:0]  ALUControl;
  logic [31:0] Mdatain;
  logic [31:0] R0_data_out, R4_data_out, R5_data_out, big_boy_bus;
  logic [31:0] MDR_data_in, MDR_data_out, Y_data_out;
  logic [63:0] Z_data_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_mdr;

  phase1_datapath dut (
    .Clock(Clock), .Clear(Clear),
    .R0in(R0in), .R4in(R4in), .R5in(R5in), .MARin(MARin), .PCin(PCin), .IRin(IRin),
    .Yin(Yin), .MDRin(MDRin), .Zin(Zin), .IncrementPC(IncrementPC),
    .R4out(R4out), .R5out(R5out), .PCout(PCout), .ZLOout(ZLOout), .MDRout(MDRout),
    .Read(Read), .ALUControl(ALUControl), .Mdatain(Mdatain),
    .R0_data_out(R0_data_out), .R4_data_out(R4_data_out), .R5_data_out(R5_data_out),
    .big_boy_bus(big_boy_bus), .MDR_data_in(MDR_data_in), .MDR_data_out(MDR_data_out),
    .Y_data_out(Y_data_out), .Z_data_out(Z_data_out)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {R0in, R4in, R5in, MARin, PCin, IRin, Yin, MDRin, Zin, IncrementPC} = '0;
    {R4out, R5out, PCout, ZLOout, MDRout, Read} = '0;
    ALUControl = 5'b00000;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
    last_mdr = v;
  endtask

  task automatic load_y(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; Yin = 1;
    tick();
  endtask

  task automatic alu_op(input logic [31:0] b, input logic [4:0] op);
    load_mdr(b);
    MDRout = 1; Zin = 1; ALUControl = op;
    tick();
  endtask

  initial begin
    idle();
    Mdatain = 32'h0;
    Clear = 1'b0;
    #1;
    check("reset_r4", {32'h0, R4_data_out}, 64'h0);
    check("reset_z", Z_data_out, 64'h0);
    check("reset_bus_idle", {32'h0, big_boy_bus}, 64'h0);
    @(negedge Clock);
    Clear = 1'b1;
    #1;

    load_mdr(32'h12);
    check("mdr_load_12", {32'h0, MDR_data_out}, 64'h12);
    MDRout = 1; R4in = 1;
    #1;
    check("mdr_in_from_bus", {32'h0, MDR_data_in}, 64'h12);
    tick();
    check("r4_load", {32'h0, R4_data_out}, 64'h12);
    load_mdr(32'h14);
    MDRout = 1; R5in = 1;
    tick();
    check("r5_load", {32'h0, R5_data_out}, 64'h14);
    load_mdr(32'h18);
    MDRout = 1; R0in = 1;
    tick();
    check("r0_load", {32'h0, R0_data_out}, 64'h18);

    // Fetch and add; Y is still 0 from reset so ADD passes PC through.
    PCout = 1; MARin = 1; Zin = 1; ALUControl = 5'b00000;
    tick();
    check("t0_z_is_pc", Z_data_out, 64'h0);
    check("t0_mar", {32'h0, dut.mar}, 64'h0);
    ZLOout = 1; IncrementPC = 1; Read = 1; MDRin = 1; Mdatain = 32'h28918000;
    tick();
    check("t1_mdr", {32'h0, MDR_data_out}, 64'h28918000);
    PCout = 1;
    #1;
    check("t1_pc_on_bus", {32'h0, big_boy_bus}, 64'h1);
    idle();
    MDRout = 1; IRin = 1;
    tick();
    check("t2_ir", {32'h0, dut.ir}, 64'h28918000);
    R4out = 1; Yin = 1;
    tick();
    check("t3_y", {32'h0, Y_data_out}, 64'h12);
    R5out = 1; Zin = 1; ALUControl = 5'b00000;
    tick();
    check("t4_add", Z_data_out, 64'h26);
    ZLOout = 1; R0in = 1;
    tick();
    check("t5_r0", {32'h0, R0_data_out}, 64'h26);

    load_y(32'hFFFFFFFE);
    alu_op(32'd3, 5'b01001);
    check("mul_neg", Z_data_out, 64'hFFFFFFFFFFFFFFFA);
    load_y(32'd7);
    alu_op(32'd2, 5'b01010);
    check("div_7_2", Z_data_out, 64'h0000000100000003);
    alu_op(32'd0, 5'b01010);
    check("div_by_zero", Z_data_out, 64'h0);
    alu_op(32'd2, 5'b00001);
    check("sub_7_2", Z_data_out, 64'h5);
    load_y(32'd2);
    alu_op(32'd7, 5'b00001);
    check("sub_wrap", Z_data_out, 64'h00000000FFFFFFFB);
    alu_op(32'd5, 5'b01011);
    check("neg_5", Z_data_out, 64'h00000000FFFFFFFB);

    load_y(32'h80000001);
    alu_op(32'd1, 5'b00100);
    check("shr", Z_data_out, 64'h40000000);
    alu_op(32'd1, 5'b00101);
    check("shra", Z_data_out, 64'hC0000000);
    alu_op(32'd1, 5'b01000);
    check("rol", Z_data_out, 64'h3);
    alu_op(32'd1, 5'b00111);
    check("ror", Z_data_out, 64'hC0000000);
    alu_op(32'd1, 5'b00110);
    check("shl", Z_data_out, 64'h2);
    alu_op(32'd1, 5'b00010);
    check("and", Z_data_out, 64'h1);
    alu_op(32'd1, 5'b00011);
    check("or", Z_data_out, 64'h80000001);
    alu_op(32'd1, 5'b01100);
    check("not", Z_data_out, 64'hFFFFFFFE);
    alu_op(32'd33, 5'b00100);
    check("shr_amt_mod32", Z_data_out, 64'h40000000);
    alu_op(32'd1, 5'b11111);
    check("undefined_op", Z_data_out, 64'h0);

    load_mdr(32'hA5A5_0001);
    MDRout = 1; R4out = 1;
    #1;
    check("prio_mdr_over_r4", {32'h0, big_boy_bus}, {32'h0, last_mdr});
    idle();
    ZLOout = 1; R4out = 1; PCout = 1;
    #1;
    check("prio_zlo_over_pc", {32'h0, big_boy_bus}, 64'h0);
    idle();
    PCout = 1; R5out = 1;
    #1;
    check("prio_pc_over_r5", {32'h0, big_boy_bus}, 64'h1);
    idle();
    #1;
    check("bus_idle_zero", {32'h0, big_boy_bus}, 64'h0);

    // Load and drive R4 together: captures the pre-edge bus value.
    load_mdr(32'h12);
    MDRout = 1; R4in = 1;
    tick();
    R4out = 1; R4in = 1;
    tick();
    check("r4_self_load", {32'h0, R4_data_out}, 64'h12);

    #2;
    Clear = 1'b0;
    #1;
    check("clear_r4", {32'h0, R4_data_out}, 64'h0);
    check("clear_mdr", {32'h0, MDR_data_out}, 64'h0);
    check("clear_y", {32'h0, Y_data_out}, 64'h0);
    check("clear_z", Z_data_out, 64'h0);
    Mdatain = 32'h77; Read = 1; MDRin = 1; IncrementPC = 1;
    @(posedge Clock);
    #1;
    check("clear_ignores_strobe", {32'h0, MDR_data_out}, 64'h0);
    idle();
    PCout = 1;
    #1;
    check("clear_pc", {32'h0, big_boy_bus}, 64'h0);
    idle();
    @(negedge Clock);
    Clear = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
